// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } arb_state_t;

  localparam int DEF_MAX_DM_STREAK = 4;
  localparam int DEF_TIMEOUT       = 255;

endpackage

// File: rtl/mem_port_arbiter_streak_counter.sv
// Saturating count of consecutive data grants taken while a fetch was waiting.
module arb_streak_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX = DEF_MAX_DM_STREAK
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam logic [3:0] SAT_VAL = 4'(MAX);

  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && cnt != SAT_VAL) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign sat = (cnt == SAT_VAL);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data-stage accesses onto one single-ported memory,
// with data priority, fetch anti-starvation and a response watchdog.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW            = 32,
  parameter int DW            = 32,
  parameter int MAX_DM_STREAK = DEF_MAX_DM_STREAK,
  parameter int TIMEOUT       = DEF_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  output logic          if_stall,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_valid,
  output logic          dm_stall,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          err
);

  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

  arb_state_t    state;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          we_q;
  logic [7:0]    wdog;
  logic          err_q;

  logic idle, busy, dm_win, if_win, streak_sat, streak_inc, streak_clr;

  assign idle = (state == IDLE);
  assign busy = ~idle;

  // A saturated streak hands the port to a waiting fetch even if data wants it.
  assign dm_win     = idle & dm_req & ~(if_req & streak_sat);
  assign if_win     = idle & if_req & ~dm_win;
  assign streak_inc = dm_win & if_req;
  assign streak_clr = if_win | (dm_win & ~if_req);

  arb_streak_counter #(
    .MAX (MAX_DM_STREAK)
  ) u_streak (
    .clk (clk),
    .rst (rst),
    .inc (streak_inc),
    .clr (streak_clr),
    .sat (streak_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      wdog    <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wdog <= '0;
          if (dm_win) begin
            state   <= BUSY_DM;
            addr_q  <= dm_addr;
            wdata_q <= dm_wdata;
            we_q    <= dm_we;
          end else if (if_win) begin
            state  <= BUSY_IF;
            addr_q <= if_addr;
            we_q   <= 1'b0;
          end
        end
        BUSY_IF, BUSY_DM: begin
          if (mem_ready) begin
            state <= IDLE;
            wdog  <= '0;
          end else if (wdog == WDOG_LAST) begin
            // Abandon the access silently; the requester is still stalled and re-arbitrates.
            state <= IDLE;
            wdog  <= '0;
            err_q <= 1'b1;
          end else begin
            wdog <= wdog + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign if_valid  = (state == BUSY_IF) & mem_ready;
  assign dm_valid  = (state == BUSY_DM) & mem_ready;
  assign if_rdata  = if_valid ? mem_rdata : '0;
  assign dm_rdata  = dm_valid ? mem_rdata : '0;
  assign if_stall  = if_req & ~if_valid;
  assign dm_stall  = dm_req & ~dm_valid;
  assign mem_en    = busy;
  assign mem_we    = busy & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int MAXS = 4;
  localparam int TMO  = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_req, dm_we, mem_ready;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_valid, if_stall, dm_valid, dm_stall, mem_en, mem_we, err;

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(
    .AW (32), .DW (32), .MAX_DM_STREAK (MAXS), .TIMEOUT (TMO)
  ) dut (
    .clk (clk), .rst (rst),
    .if_req (if_req), .if_addr (if_addr), .if_rdata (if_rdata),
    .if_valid (if_valid), .if_stall (if_stall),
    .dm_req (dm_req), .dm_we (dm_we), .dm_addr (dm_addr), .dm_wdata (dm_wdata),
    .dm_rdata (dm_rdata), .dm_valid (dm_valid), .dm_stall (dm_stall),
    .mem_en (mem_en), .mem_we (mem_we), .mem_addr (mem_addr), .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata), .mem_ready (mem_ready), .err (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Transaction-level model: who owns the port, how long it has waited, and what was latched.
  int          m_owner;   // 0 none, 1 fetch, 2 data
  int          m_wait;
  int          m_streak;
  bit          m_err;
  bit          m_we;
  logic [31:0] m_addr, m_wdata;
  bit          exp_ifv, exp_dmv, if_done, dm_done;

  initial begin
    m_owner = 0; m_wait = 0; m_streak = 0; m_err = 0; m_we = 0;
    m_addr = '0; m_wdata = '0; if_done = 0; dm_done = 0;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_owner = 0; m_wait = 0; m_streak = 0; m_err = 0;
      m_addr = '0; m_wdata = '0; m_we = 0;
    end else if (m_owner == 0) begin
      m_wait = 0;
      if (dm_req && !(if_req && m_streak == MAXS)) begin
        m_owner  = 2;
        m_addr   = dm_addr;
        m_wdata  = dm_wdata;
        m_we     = dm_we;
        m_streak = if_req ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
      end else if (if_req) begin
        m_owner  = 1;
        m_addr   = if_addr;
        m_we     = 0;
        m_streak = 0;
      end
    end else if (mem_ready) begin
      m_owner = 0;
    end else begin
      m_wait++;
      if (m_wait >= TMO) begin
        m_owner = 0;
        m_err   = 1;
        m_wait  = 0;
      end
    end
  end

  always @(negedge clk) begin
    exp_ifv = (m_owner == 1) && mem_ready;
    exp_dmv = (m_owner == 2) && mem_ready;
    chk("if_valid", if_valid, exp_ifv);
    chk("dm_valid", dm_valid, exp_dmv);
    if (exp_ifv) chk("if_rdata", if_rdata, mem_rdata);
    if (exp_dmv && !m_we) chk("dm_rdata", dm_rdata, mem_rdata);
    chk("if_stall", if_stall, if_req && !exp_ifv);
    chk("dm_stall", dm_stall, dm_req && !exp_dmv);
    chk("mem_en", mem_en, m_owner != 0);
    chk("mem_we", mem_we, (m_owner != 0) && m_we);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("err", err, m_err);
    if_done = exp_ifv;
    dm_done = exp_dmv;
  end

  task automatic idle_inputs();
    if_req = 0; dm_req = 0; dm_we = 0; mem_ready = 0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
  endtask

  bit   grants[$];
  logic prev_en;

  initial begin
    rst = 1;
    idle_inputs();
    repeat (2) tick();
    rst = 0;
    mid();
    chk("rst_mem_en", mem_en, 0);
    chk("rst_err", err, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_we", mem_we, 0);
    tick();

    // Single fetch, memory answers on the first busy cycle
    if_req = 1; if_addr = 32'h40; mem_ready = 1; mem_rdata = 32'h00A00093;
    mid(); chk("t1_c0_valid", if_valid, 0); chk("t1_c0_stall", if_stall, 1); chk("t1_c0_en", mem_en, 0);
    tick();
    mid(); chk("t1_c1_valid", if_valid, 1); chk("t1_c1_rdata", if_rdata, 32'h00A00093);
    chk("t1_c1_stall", if_stall, 0); chk("t1_c1_en", mem_en, 1); chk("t1_c1_addr", mem_addr, 32'h40);
    tick();
    if_req = 0; mem_ready = 0;
    mid(); chk("t1_c2_en", mem_en, 0); chk("t1_c2_valid", if_valid, 0);
    tick();

    // Simultaneous requests: data store first, fetch follows
    if_req = 1; if_addr = 32'h44; dm_req = 1; dm_we = 1; dm_addr = 32'h80; dm_wdata = 32'hDEADBEEF;
    mid(); chk("t2_c0_en", mem_en, 0); chk("t2_c0_ifstall", if_stall, 1);
    tick();
    mid(); chk("t2_c1_we", mem_we, 1); chk("t2_c1_addr", mem_addr, 32'h80);
    chk("t2_c1_wdata", mem_wdata, 32'hDEADBEEF); chk("t2_c1_ifstall", if_stall, 1);
    tick();
    mem_ready = 1;
    mid(); chk("t2_c2_we", mem_we, 1); chk("t2_c2_addr", mem_addr, 32'h80);
    chk("t2_c2_dmvalid", dm_valid, 1); chk("t2_c2_ifstall", if_stall, 1);
    tick();
    dm_req = 0; dm_we = 0;
    mid(); chk("t2_c3_en", mem_en, 0); chk("t2_c3_ifstall", if_stall, 1);
    tick();
    mem_rdata = 32'h00100113;
    mid(); chk("t2_c4_addr", mem_addr, 32'h44); chk("t2_c4_we", mem_we, 0);
    chk("t2_c4_ifvalid", if_valid, 1); chk("t2_c4_ifstall", if_stall, 0);
    tick();
    idle_inputs();
    tick();

    // Data request dropped while its access is in flight
    dm_req = 1; dm_addr = 32'h90; if_req = 1; if_addr = 32'h48;
    mid(); tick();
    dm_req = 0;
    mid(); chk("t6_c1_en", mem_en, 1); chk("t6_c1_addr", mem_addr, 32'h90); chk("t6_c1_valid", dm_valid, 0);
    tick();
    mem_ready = 1; mem_rdata = 32'h00001234;
    mid(); chk("t6_c2_valid", dm_valid, 1); chk("t6_c2_rdata", dm_rdata, 32'h00001234);
    tick();
    mem_ready = 0;
    mid(); chk("t6_c3_en", mem_en, 0); chk("t6_c3_ifstall", if_stall, 1);
    tick();
    mid(); chk("t6_c4_en", mem_en, 1); chk("t6_c4_addr", mem_addr, 32'h48);
    tick();
    mem_ready = 1;
    mid(); chk("t6_c5_ifvalid", if_valid, 1);
    tick();
    idle_inputs();
    tick();

    // Continuous data pressure with a waiting fetch: 4 data grants per fetch grant
    dm_req = 1; dm_addr = 32'h100; if_req = 1; if_addr = 32'h200; mem_ready = 1;
    prev_en = 0;
    for (int c = 0; c < 40; c++) begin
      mid();
      if (mem_en === 1'b1 && prev_en === 1'b0) grants.push_back(mem_addr == 32'h200);
      prev_en = mem_en;
      tick();
    end
    chk("t3_grant_count", grants.size(), 20);
    for (int i = 0; i < grants.size(); i++) chk("t3_grant_order", grants[i], (i % 5) == 4);
    idle_inputs();
    tick();

    // Memory never answers: watchdog fires, access is re-granted
    dm_req = 1; dm_addr = 32'hC0;
    mid(); chk("t4_c0_en", mem_en, 0);
    tick();
    for (int c = 1; c <= TMO; c++) begin
      mid(); chk("t4_busy_en", mem_en, 1); chk("t4_no_valid", dm_valid, 0); chk("t4_err_low", err, 0);
      tick();
    end
    mid(); chk("t4_to_en", mem_en, 0); chk("t4_to_err", err, 1); chk("t4_to_stall", dm_stall, 1);
    tick();
    mem_ready = 1;
    mid(); chk("t4_regrant_en", mem_en, 1); chk("t4_regrant_addr", mem_addr, 32'hC0);
    chk("t4_regrant_valid", dm_valid, 1); chk("t4_regrant_err", err, 1);
    tick();
    idle_inputs();
    repeat (3) tick();
    mid(); chk("t4_err_sticky", err, 1);
    tick();

    // Reset in the second busy cycle of a data access
    dm_req = 1; dm_we = 1; dm_addr = 32'hA0; dm_wdata = 32'h55;
    mid(); tick();
    mid(); chk("t5_c1_en", mem_en, 1); tick();
    rst = 1;
    mid(); chk("t5_c2_en", mem_en, 1); chk("t5_c2_valid", dm_valid, 0); tick();
    rst = 0; dm_req = 0; dm_we = 0;
    mid(); chk("t5_post_en", mem_en, 0); chk("t5_post_valid", dm_valid, 0);
    chk("t5_post_err", err, 0); chk("t5_post_addr", mem_addr, 0);
    tick();
    if_req = 1; if_addr = 32'h60; mem_ready = 1; mem_rdata = 32'h00000013;
    mid(); chk("t5_f_c0_en", mem_en, 0); tick();
    mid(); chk("t5_f_c1_valid", if_valid, 1); chk("t5_f_c1_rdata", if_rdata, 32'h00000013);
    tick();
    idle_inputs();
    tick();

    // Randomized traffic; the negedge compare process checks every cycle
    for (int n = 0; n < 3000; n++) begin
      if (if_done || !if_req) begin
        if_req  = ($urandom % 3) != 0;
        if_addr = $urandom;
      end
      if (dm_done || !dm_req) begin
        dm_req   = ($urandom % 2) != 0;
        dm_we    = $urandom % 2;
        dm_addr  = $urandom;
        dm_wdata = $urandom;
      end
      mem_ready = ($urandom % 4) != 0;
      mem_rdata = $urandom;
      rst       = ($urandom % 400) == 0;
      tick();
    end
    rst = 0;
    idle_inputs();
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified instruction/data memory between the fetch stage (PC-addressed) and the data-memory stage (ALU-addressed load/store).
- Arbitrates between the two requesters: data has priority, and fetch is protected from starvation by a streak counter.
- Sequences a variable-latency memory handshake and generates per-requester valid/stall signals for the core's PC-load and pipeline-freeze logic.
- Flags a memory that never responds via a watchdog.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MAX_DM_STREAK, 4, consecutive data grants allowed while a fetch waits (1..15).
- TIMEOUT, 255, max BUSY cycles without mem_ready before error (1..255).

Ports:
- clk  in  1  clock; rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held until if_valid.
- if_addr  in  AW  fetch address.
- if_rdata  out  DW  fetched instruction; valid when if_valid.
- if_valid  out  1  fetch completes this cycle.
- if_stall  out  1  = if_req & ~if_valid.
- dm_req  in  1  data request (MemRead|MemWrite); held until dm_valid.
- dm_we  in  1  1 = store.
- dm_addr  in  AW  data address.
- dm_wdata  in  DW  store data.
- dm_rdata  out  DW  load data; valid when dm_valid.
- dm_valid  out  1  data access completes this cycle.
- dm_stall  out  1  = dm_req & ~dm_valid.
- mem_en  out  1  memory transaction active.
- mem_we  out  1  write strobe.
- mem_addr  out  AW  latched address.
- mem_wdata  out  DW  latched write data.
- mem_rdata  in  DW  memory read data.
- mem_ready  in  1  memory completes this cycle.
- err  out  1  sticky timeout flag.

Behaviour:
- FSM states: IDLE, BUSY_IF, BUSY_DM.
- Reset: state=IDLE; streak=0; wdog=0; err=0; latched addr/wdata/we=0.
  - All outputs 0 from the cycle after rst is sampled high.
  - Reset mid-transaction abandons the access; no valid is produced.
- IDLE arbitration, evaluated combinationally, registered at the edge:
  - dm_req & ~(if_req & streak==MAX_DM_STREAK) -> BUSY_DM.
  - else if if_req -> BUSY_IF.
  - else stay in IDLE.
  - On grant, latch the granted requester's addr (and we/wdata for DM; we=0 for IF).
- Streak counter:
  - On a DM grant with if_req=1: streak+1.
  - On an IF grant, or a DM grant with if_req=0: streak=0.
  - Saturates at MAX_DM_STREAK.
- BUSY_x:
  - mem_en=1, mem_we=latched we, mem_addr/mem_wdata=latched values, stable for the whole state.
  - Inputs are not re-sampled.
- Completion:
  - mem_ready=1 in BUSY_IF -> if_valid=1 and if_rdata=mem_rdata the same cycle (combinational), then -> IDLE.
  - Same for BUSY_DM with dm_valid/dm_rdata.
  - A store still pulses dm_valid; dm_rdata is don't-care.
  - mem_ready is ignored in IDLE.
- Latency: minimum two cycles per access (grant cycle + one BUSY cycle). Each extra cycle without mem_ready adds one.
- Valid signals are never high outside the matching BUSY state, and never both high in the same cycle.
- Requester deasserts req during BUSY: the access still completes and valid still pulses; the requester ignores it. No abort.
- Simultaneous requests:
  - DM wins unless the streak is saturated.
  - The loser's stall stays high through the winner's transaction and the following IDLE grant cycle.
- Watchdog:
  - wdog counts BUSY cycles with mem_ready=0 and clears in IDLE.
  - When wdog reaches TIMEOUT: err<=1 (sticky until rst), FSM -> IDLE, and no valid is produced.
  - The requester keeps stalling and is re-arbitrated.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, BUSY_IF=2'd1, BUSY_DM=2'd2) and the default constants MAX_DM_STREAK and TIMEOUT.
- One sub-module, arb_streak_counter: saturating counter with inc/clr/sat outputs.
- The FSM and latches stay in the top module.

Test Plan:
1. Single fetch, if_addr=0x40, mem_ready high on the first BUSY cycle, mem_rdata=0x00A00093:
   - if_valid is high exactly in cycle 1 with if_rdata=0x00A00093.
   - if_stall is high in cycle 0 only.
   - mem_en is high in cycle 1 only.
2. Simultaneous if_req and dm_req (store, dm_addr=0x80, wdata=0xDEADBEEF), mem_ready one cycle late:
   - The DM grant goes first: mem_we=1 and mem_addr=0x80 held for 2 cycles.
   - The IF grant follows in the next IDLE.
   - if_stall is high for 4 cycles.
3. dm_req held continuously with if_req=1:
   - Exactly 4 DM grants, then 1 IF grant, then the streak resets.
   - Repeats 4:1 over 20 grants.
4. mem_ready held low with TIMEOUT=8:
   - After 8 BUSY cycles, err=1 and state returns to IDLE.
   - No valid pulse.
   - The pending request is re-granted next.
   - err stays 1 until rst.
5. Reset mid-transaction:
   - rst asserted in the second BUSY_DM cycle.
   - The next cycle has mem_en=0, dm_valid=0, err=0, and state is IDLE.
   - After rst is released, a new fetch completes normally.
6. dm_req dropped during BUSY_DM:
   - dm_valid still pulses on mem_ready.
   - Next IDLE grants the pending if_req.
